// File: rtl/som_dec_nx2n_seq.sv
// rtl/som_dec_nx2n_seq.sv - registered N-to-2^N decoder with mask-selected sum-of-minterms output and sweep FSM
// Optional truth-table capture on ttab when SOM_DEC_TTAB_CAPTURE_EN is defined.
module som_dec_nx2n_seq #(
   parameter int                N        = 4,
   parameter logic [(2**N)-1:0] MASK_RST = 16'hF830
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [N-1:0]        sel,
   input  logic                mask_ld,
   input  logic [(2**N)-1:0]   mask_in,
   input  logic                start,
   output logic [(2**N)-1:0]   y,
   output logic                f,
   output logic [N-1:0]        code_o,
   output logic                valid,
   output logic                busy,
   output logic                done,
   output logic [(2**N)-1:0]   ttab
);
   localparam int               OUT_W = 2**N;
   localparam logic [N:0]       LAST  = (N+1)'(OUT_W);
   localparam logic [OUT_W-1:0] ONE   = {{(OUT_W-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           state;
   logic [OUT_W-1:0] mask;
   logic [N:0]       cnt;
   logic [N-1:0]     code_c;
   logic [OUT_W-1:0] m_eff;
   logic [OUT_W-1:0] dec_y;
   logic             dec_f;
   logic             sweep_go;

   // A mask load in IDLE is visible on the same edge, so a sweep started with it uses the new mask.
   always_comb begin
      m_eff    = (state == IDLE && mask_ld) ? mask_in : mask;
      dec_y    = en ? (ONE << sel) : '0;
      dec_f    = en & m_eff[sel];
      code_c   = cnt[N-1:0];
      sweep_go = (state == IDLE) && en && start;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mask   <= MASK_RST;
         cnt    <= '0;
         y      <= '0;
         f      <= 1'b0;
         code_o <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               mask <= m_eff;
               if (sweep_go) begin
                  state  <= SWEEP;
                  cnt    <= (N+1)'(1);
                  y      <= ONE;
                  f      <= m_eff[0];
                  code_o <= '0;
                  valid  <= 1'b1;
                  busy   <= 1'b1;
               end else begin
                  y      <= dec_y;
                  f      <= dec_f;
                  code_o <= sel;
                  valid  <= en;
               end
            end
            SWEEP: begin
               if (!en || cnt == LAST) begin
                  // Abort and completion both fall back to plain decode of sel.
                  state  <= IDLE;
                  cnt    <= '0;
                  busy   <= 1'b0;
                  done   <= en;
                  y      <= dec_y;
                  f      <= dec_f;
                  code_o <= sel;
                  valid  <= en;
               end else begin
                  cnt    <= cnt + 1'b1;
                  y      <= ONE << code_c;
                  f      <= mask[code_c];
                  code_o <= code_c;
                  valid  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOM_DEC_TTAB_CAPTURE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ttab <= '0;
      end else if (sweep_go) begin
         ttab <= {{(OUT_W-1){1'b0}}, m_eff[0]};
      end else if (state == SWEEP && en && cnt != LAST) begin
         ttab[code_c] <= mask[code_c];
      end
   end
`else
   assign ttab = '0;
`endif

endmodule
